// File: rtl/clk_and_exerciser.sv
// clk_and_exerciser: LFSR-driven stimulus generator and response checker
// for a clocked WIDTH-bit AND core. Issues NUM_VECTORS operand pairs and
// compares each returned result LATENCY cycles later against a local a&b.
// The result is a pass flag, a saturating error count and the index of the
// first failing vector.
module clk_and_exerciser #(
  parameter int               WIDTH       = 8,
  parameter int               LATENCY     = 1,
  parameter int               NUM_VECTORS = 256,
  parameter logic [WIDTH-1:0] SEED_A      = 8'h01,
  parameter logic [WIDTH-1:0] SEED_B      = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_err_idx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] LFSR_MASK  = WIDTH'(8'hB8);
  localparam logic [8:0]       LAST_VEC   = 9'(NUM_VECTORS - 1);
  localparam logic [8:0]       LAST_DRAIN = 9'(LATENCY - 1);

  // Galois right-shift LFSR step.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
  logic [8:0]       cnt_q,    cnt_d;     // vector index in RUN, cycle in DRAIN
  logic [7:0]       err_q,    err_d;
  logic [7:0]       first_q,  first_d;

  // Delay line aligning the expected value with the core's returned result.
  logic [LATENCY-1:0] dl_vld_q;
  logic [WIDTH-1:0]   dl_exp_q [LATENCY];
  logic [7:0]         dl_idx_q [LATENCY];
  logic               push_vld;

  logic             tail_vld;
  logic [WIDTH-1:0] tail_exp;
  logic [7:0]       tail_idx;

  assign tail_vld = dl_vld_q[LATENCY-1];
  assign tail_exp = dl_exp_q[LATENCY-1];
  assign tail_idx = dl_idx_q[LATENCY-1];

  // Next-state logic: run sequencing, LFSR stepping and result checking.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    first_d  = first_q;
    push_vld = 1'b0;

    // Only vectors of the current run occupy the delay line, so a valid tail
    // is always a live check. err_q==0 marks the first mismatch of the run;
    // saturation keeps it from ever returning to zero mid-run.
    if (tail_vld && (y_in != tail_exp)) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'd0)  first_d = tail_idx;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          lfsr_a_d = SEED_A;
          lfsr_b_d = SEED_B;
          cnt_d    = '0;
          err_d    = '0;
          first_d  = '0;
        end
      end
      ST_RUN: begin
        push_vld = 1'b1;
        lfsr_a_d = lfsr_next(lfsr_a_q);
        lfsr_b_d = lfsr_next(lfsr_b_q);
        if (cnt_q == LAST_VEC) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin  // ST_DRAIN
        if (cnt_q == LAST_DRAIN) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= ST_IDLE;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      cnt_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  // Delay-line valid bits: cleared on reset, shifted every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld_q <= '0;
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) dl_vld_q[k] <= dl_vld_q[k-1];
      dl_vld_q[0] <= push_vld;
    end
  end

  // Delay-line payload: shifted alongside the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; the valid bits alone qualify its contents.
    for (int k = LATENCY - 1; k > 0; k--) begin
      dl_exp_q[k] <= dl_exp_q[k-1];
      dl_idx_q[k] <= dl_idx_q[k-1];
    end
    dl_exp_q[0] <= lfsr_a_q & lfsr_b_q;
    dl_idx_q[0] <= cnt_q[7:0];
  end

  assign a_out         = (state_q == ST_RUN) ? lfsr_a_q : '0;
  assign b_out         = (state_q == ST_RUN) ? lfsr_b_q : '0;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_q == 8'd0);
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_clk_and_exerciser.sv
// Directed bench for clk_and_exerciser. Three instances cover the default
// configuration, LATENCY=2 and NUM_VECTORS=1; a small AND-core model with
// selectable faults closes the loop for each.
module tb_clk_and_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start_v;
  int         mode;     // 0 ideal, 1 bit0 stuck-0, 2 inverted, 3 extra latency, 4 bit7 stuck-0

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] a1, b1, y1, err1, first1;
  logic [7:0] a2, b2, y2, err2, first2;
  logic [7:0] a3, b3, y3, err3, first3;
  logic       busy1, done1, pass1;
  logic       busy2, done2, pass2;
  logic       busy3, done3, pass3;
  logic [2:0] done_v;
  assign done_v = {done3, done2, done1};

  clk_and_exerciser dut1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_idx(first1));

  clk_and_exerciser #(.LATENCY(2), .NUM_VECTORS(16)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_idx(first2));

  clk_and_exerciser #(.NUM_VECTORS(1)) dut3 (
    .clk(clk), .reset(reset), .start(start_v[2]), .a_out(a3), .b_out(b3), .y_in(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_err_idx(first3));

  // AND-core models: one-stage for dut1/dut3 (plus a second stage for the
  // latency fault), two-stage ideal core for dut2.
  logic [7:0] c1_s1, c1_s2, c2_s1, c2_s2, c3_s1;
  always_ff @(posedge clk) begin
    c1_s1 <= a1 & b1;
    c1_s2 <= c1_s1;
    c2_s1 <= a2 & b2;
    c2_s2 <= c2_s1;
    c3_s1 <= a3 & b3;
  end

  function automatic logic [7:0] core_out(input int m, input logic [7:0] v, input logic [7:0] late);
    case (m)
      1:       return v & 8'hFE;
      2:       return ~v;
      3:       return late;
      4:       return v & 8'h7F;
      default: return v;
    endcase
  endfunction

  assign y1 = core_out(mode, c1_s1, c1_s2);
  assign y2 = c2_s2;
  assign y3 = core_out(mode, c3_s1, c3_s1);

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Expected saturated mismatch count when the bits in mask are forced to 0.
  function automatic int ref_count(input logic [7:0] mask);
    logic [7:0] a = 8'h01;
    logic [7:0] b = 8'hFF;
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      if (((a & b) & mask) != 8'h00) n++;
      a = lfsr_step(a);
      b = lfsr_step(b);
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] a_log [4];
  logic [7:0] b_log [4];
  logic       busy_log;

  // Start a run on instance `which`, optionally pulse start again at cycle
  // pulse_at, and return the cycle (start edge = E0, cycle 1 after it) in
  // which done was first seen. Bounded by a cycle budget.
  task automatic run(input int which, input int pulse_at, output int cyc);
    start_v[which] = 1'b1;
    @(posedge clk); #1;
    start_v[which] = 1'b0;
    cyc = 1;
    busy_log = busy1;
    while (!done_v[which] && cyc < 1000) begin
      if (which == 0 && cyc < 4) begin
        a_log[cyc] = a1;
        b_log[cyc] = b1;
      end
      if (cyc == pulse_at) start_v[which] = 1'b1;
      @(posedge clk); #1;
      start_v[which] = 1'b0;
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    reset   = 1'b1;
    start_v = '0;
    mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a",     a1,     8'h00);
    check("rst_b",     b1,     8'h00);
    check("rst_busy",  busy1,  1'b0);
    check("rst_done",  done1,  1'b0);
    check("rst_pass",  pass1,  1'b0);
    check("rst_err",   err1,   8'h00);
    check("rst_first", first1, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // Ideal core, with a start pulse in RUN cycle 10 that must be ignored.
    mode = 0;
    run(0, 10, cyc);
    check("ideal_busy_c1", busy_log, 1'b1);
    check("ideal_a_v0",  a_log[1], 8'h01);
    check("ideal_b_v0",  b_log[1], 8'hFF);
    check("ideal_a_v1",  a_log[2], 8'hB8);
    check("ideal_b_v1",  b_log[2], 8'hC7);
    check("ideal_a_v2",  a_log[3], 8'h5C);
    check("ideal_cycle", cyc,      258);
    check("ideal_pass",  pass1,    1'b1);
    check("ideal_err",   err1,     8'h00);
    check("ideal_first", first1,   8'h00);
    check("done_a_zero", a1,       8'h00);
    check("done_busy",   busy1,    1'b0);

    // Restart from DONE with bit0 stuck at 0: same sequence, fresh counters.
    mode = 1;
    run(0, 0, cyc);
    check("stk0_a_v0",  a_log[1], 8'h01);
    check("stk0_b_v0",  b_log[1], 8'hFF);
    check("stk0_a_v1",  a_log[2], 8'hB8);
    check("stk0_cycle", cyc,      258);
    check("stk0_err",   err1,     ref_count(8'h01));
    check("stk0_first", first1,   8'h00);
    check("stk0_pass",  pass1,    1'b0);

    // Bit7 stuck at 0: vector0 (01) is clean, vector1 (80) is the first error.
    mode = 4;
    run(0, 0, cyc);
    check("stk7_err",   err1,   ref_count(8'h80));
    check("stk7_first", first1, 8'h01);
    check("stk7_pass",  pass1,  1'b0);

    // Inverted result: every vector mismatches, count saturates.
    mode = 2;
    run(0, 0, cyc);
    check("inv_err",   err1,   8'd255);
    check("inv_first", first1, 8'h00);
    check("inv_pass",  pass1,  1'b0);

    // Core slower than the configured latency.
    mode = 3;
    run(0, 0, cyc);
    check("lat2_err_nonzero", err1 != 8'h00, 1'b1);
    check("lat2_pass",        pass1,         1'b0);

    // Reset in RUN cycle 100 with errors already counted.
    mode = 1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_rst_err_nonzero", err1 != 8'h00, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_a",     a1,     8'h00);
    check("abort_b",     b1,     8'h00);
    check("abort_busy",  busy1,  1'b0);
    check("abort_done",  done1,  1'b0);
    check("abort_pass",  pass1,  1'b0);
    check("abort_err",   err1,   8'h00);
    check("abort_first", first1, 8'h00);
    mode = 0;
    run(0, 0, cyc);
    check("after_abort_cycle", cyc,   258);
    check("after_abort_pass",  pass1, 1'b1);
    check("after_abort_err",   err1,  8'h00);

    // LATENCY=2 instance against a two-stage core: 16 + 2 + 1.
    run(1, 0, cyc);
    check("l2_cycle", cyc,  19);
    check("l2_pass",  pass2, 1'b1);
    check("l2_err",   err2,  8'h00);

    // NUM_VECTORS=1: one RUN cycle, one DRAIN cycle, done in cycle 3.
    mode = 1;
    run(2, 0, cyc);
    check("n1_cycle", cyc,    3);
    check("n1_err",   err3,   8'h01);
    check("n1_first", first3, 8'h00);
    check("n1_pass",  pass3,  1'b0);
    mode = 0;
    run(2, 0, cyc);
    check("n1_ideal_pass", pass3, 1'b1);
    check("n1_ideal_err",  err3,  8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
